// File: rtl/s_mux_arb_pkg.sv
// Shared types and constants for the two-requester S_MUX arbiter.
package s_mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/S_MUX.sv
// SIZE-wide 2:1 multiplexer: SEL_A passes A, SEL_B passes B.
module S_MUX
    import s_mux_arb_pkg::*;
#(
    parameter int SIZE = 1
) (
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            SEL,
    output logic [SIZE-1:0] OUT
);

    assign OUT = (SEL == SEL_B) ? B : A;

endmodule

// File: rtl/s_mux_arb.sv
// Round-robin arbiter with bounded bursts in front of S_MUX, feeding a
// single-entry registered output stage with its own valid/ready handshake.
module s_mux_arb
    import s_mux_arb_pkg::*;
#(
    parameter int SIZE  = 1,
    parameter int BURST = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [SIZE-1:0] A,
    input  logic            A_VLD,
    output logic            A_RDY,
    input  logic [SIZE-1:0] B,
    input  logic            B_VLD,
    output logic            B_RDY,
    output logic [SIZE-1:0] OUT,
    output logic            OUT_VLD,
    input  logic            OUT_RDY,
    output logic            SEL,
    output logic            BUSY
);

    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    arb_state_e      state_r;
    arb_state_e      state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            last_r;
    logic            last_nxt_s;
    logic [SIZE-1:0] out_r;
    logic            out_vld_r;
    logic [SIZE-1:0] mux_out_s;
    logic            load_s;
    logic            a_rdy_s;
    logic            b_rdy_s;
    logic            sel_s;
    logic            xfer_s;

    S_MUX #(.SIZE(SIZE)) u_mux (
        .A   (A),
        .B   (B),
        .SEL (sel_s),
        .OUT (mux_out_s)
    );

    // The output stage can take a word when empty or being drained this cycle.
    assign load_s    = ~out_vld_r | OUT_RDY;
    assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    assign xfer_s    = (a_rdy_s & A_VLD) | (b_rdy_s & B_VLD);

    // Per-state handshake and mux select decode.
    always_comb begin
        a_rdy_s = 1'b0;
        b_rdy_s = 1'b0;
        sel_s   = SEL_A;
        case (state_r)
            GNT_A: begin
                a_rdy_s = load_s;
            end
            GNT_B: begin
                b_rdy_s = load_s;
                sel_s   = SEL_B;
            end
            default: begin
                sel_s = SEL_A;
            end
        endcase
    end

    // Next-state, burst counter and last-grant pointer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (A_VLD && B_VLD) begin
                    // Tie goes to the side that was not granted last.
                    if (last_r == SEL_A) begin
                        state_nxt_s = GNT_B;
                        last_nxt_s  = SEL_B;
                    end else begin
                        state_nxt_s = GNT_A;
                        last_nxt_s  = SEL_A;
                    end
                    cnt_nxt_s = '0;
                end else if (A_VLD) begin
                    state_nxt_s = GNT_A;
                    last_nxt_s  = SEL_A;
                    cnt_nxt_s   = '0;
                end else if (B_VLD) begin
                    state_nxt_s = GNT_B;
                    last_nxt_s  = SEL_B;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT_A: begin
                if (!A_VLD) begin
                    if (B_VLD) begin
                        state_nxt_s = GNT_B;
                        last_nxt_s  = SEL_B;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                    cnt_nxt_s = '0;
                end else if (load_s) begin
                    if (cnt_inc_s == BURST_C) begin
                        cnt_nxt_s = '0;
                        if (B_VLD) begin
                            state_nxt_s = GNT_B;
                            last_nxt_s  = SEL_B;
                        end else begin
                            state_nxt_s = GNT_A;
                        end
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            GNT_B: begin
                if (!B_VLD) begin
                    if (A_VLD) begin
                        state_nxt_s = GNT_A;
                        last_nxt_s  = SEL_A;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                    cnt_nxt_s = '0;
                end else if (load_s) begin
                    if (cnt_inc_s == BURST_C) begin
                        cnt_nxt_s = '0;
                        if (A_VLD) begin
                            state_nxt_s = GNT_A;
                            last_nxt_s  = SEL_A;
                        end else begin
                            state_nxt_s = GNT_B;
                        end
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            last_r  <= SEL_B;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Single-entry output register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_r     <= '0;
            out_vld_r <= 1'b0;
        end else if (xfer_s) begin
            out_r     <= mux_out_s;
            out_vld_r <= 1'b1;
        end else if (OUT_RDY) begin
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= out_vld_r;
        end
    end

    assign A_RDY   = a_rdy_s;
    assign B_RDY   = b_rdy_s;
    assign SEL     = sel_s;
    assign BUSY    = (state_r != IDLE);
    assign OUT     = out_r;
    assign OUT_VLD = out_vld_r;

endmodule

// File: tb/tb_s_mux_arb.sv
// Directed and random checks of s_mux_arb against an owner/count reference model.
module tb_s_mux_arb;

    localparam int SIZE  = 6;
    localparam int BURST = 2;
    localparam logic [5:0] WA = 6'b010001;
    localparam logic [5:0] WB = 6'b111011;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            A_VLD;
    logic            B_VLD;
    logic            OUT_RDY;
    logic            A_RDY;
    logic            B_RDY;
    logic [SIZE-1:0] OUT;
    logic            OUT_VLD;
    logic            SEL;
    logic            BUSY;

    s_mux_arb #(.SIZE(SIZE), .BURST(BURST)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .A       (A),
        .A_VLD   (A_VLD),
        .A_RDY   (A_RDY),
        .B       (B),
        .B_VLD   (B_VLD),
        .B_RDY   (B_RDY),
        .OUT     (OUT),
        .OUT_VLD (OUT_VLD),
        .OUT_RDY (OUT_RDY),
        .SEL     (SEL),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: owner -1 = nobody, 0 = A, 1 = B.
    int              m_own;
    int              m_cnt;
    int              m_last;
    logic [SIZE-1:0] m_out;
    bit              m_ovld;
    bit              acc_a;
    bit              acc_b;
    int              n_pass = 0;
    int              n_tot  = 0;
    bit              cap    = 1'b0;
    logic [SIZE-1:0] capq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_own  = -1;
        m_cnt  = 0;
        m_last = 1;
        m_out  = '0;
        m_ovld = 1'b0;
        acc_a  = 1'b0;
        acc_b  = 1'b0;
    endtask

    function automatic bit m_load();
        return !m_ovld || OUT_RDY;
    endfunction

    task automatic grant(input int side);
        m_own  = side;
        m_last = side;
        m_cnt  = 0;
    endtask

    task automatic check_all();
        bit ld;
        ld = m_load();
        chk("a_rdy", A_RDY, (m_own == 0) && ld);
        chk("b_rdy", B_RDY, (m_own == 1) && ld);
        chk("sel", SEL, m_own == 1);
        chk("busy", BUSY, m_own >= 0);
        chk("out_vld", OUT_VLD, m_ovld);
        chk("out", OUT, m_out);
    endtask

    task automatic model_step();
        bit ld;
        bit vld[2];
        int me;
        if (!RST_N) begin
            m_reset();
        end else begin
            ld     = m_load();
            vld[0] = A_VLD;
            vld[1] = B_VLD;
            acc_a  = (m_own == 0) && ld && A_VLD;
            acc_b  = (m_own == 1) && ld && B_VLD;
            if (acc_a) begin
                m_out = A; m_ovld = 1'b1;
            end else if (acc_b) begin
                m_out = B; m_ovld = 1'b1;
            end else if (OUT_RDY) begin
                m_ovld = 1'b0;
            end
            if (m_own < 0) begin
                if (vld[0] && vld[1]) grant(1 - m_last);
                else if (vld[0]) grant(0);
                else if (vld[1]) grant(1);
            end else begin
                me = m_own;
                if (!vld[me]) begin
                    if (vld[1-me]) grant(1 - me);
                    else m_own = -1;
                end else if (ld) begin
                    m_cnt++;
                    if (m_cnt == BURST) begin
                        m_cnt = 0;
                        if (vld[1-me]) grant(1 - me);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        check_all();
        if (cap && OUT_VLD && OUT_RDY) capq.push_back(OUT);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        logic [SIZE-1:0] exp_seq[6];
        exp_seq = '{WA, WA, WB, WB, WA, WA};
        m_reset();
        RST_N = 1'b0; A = WA; B = WB; A_VLD = 1'b1; B_VLD = 1'b1; OUT_RDY = 1'b1;

        // Reset held with both requesters active.
        repeat (2) cyc();
        chk("rst_out", OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rdy", {A_RDY, B_RDY}, 0);

        // Contention from reset: A first, bursts of two.
        RST_N = 1'b1;
        cap   = 1'b1;
        repeat (9) cyc();
        cap = 1'b0;
        chk("cap_count", capq.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < capq.size()) chk($sformatf("contend_%0d", i), capq[i], exp_seq[i]);
        end

        // Drain to idle, then A only.
        A_VLD = 1'b0; B_VLD = 1'b0;
        repeat (3) cyc();
        chk("idle_busy", BUSY, 0);
        A_VLD = 1'b1;
        repeat (6) cyc();
        chk("aonly_sel", SEL, 0);
        chk("aonly_out", OUT, WA);

        // A drops while B waits: handover to B, then backpressure in GNT_B.
        A_VLD = 1'b0; B_VLD = 1'b1;
        repeat (2) cyc();
        A_VLD = 1'b1; OUT_RDY = 1'b0;
        repeat (3) cyc();
        chk("bp_out", OUT, WB);
        chk("bp_brdy", B_RDY, 0);
        chk("bp_sel", SEL, 1);
        OUT_RDY = 1'b1;
        repeat (4) cyc();

        // Both drop: back to idle.
        A_VLD = 1'b0; B_VLD = 1'b0;
        repeat (2) cyc();
        chk("drop_busy", BUSY, 0);

        // Asynchronous reset between edges mid-burst.
        A_VLD = 1'b1; B_VLD = 1'b1;
        repeat (4) cyc();
        chk("pre_rst_ovld", OUT_VLD, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_out", OUT, 0);
        chk("async_ovld", OUT_VLD, 0);
        chk("async_busy", BUSY, 0);
        m_reset();
        cyc();
        RST_N = 1'b1;
        cyc();
        chk("post_rst_sel", SEL, 0);
        chk("post_rst_busy", BUSY, 1);

        // Random traffic; producers hold data and valid until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!A_VLD || acc_a) begin
                A_VLD = 1'($urandom_range(0, 1));
                A     = SIZE'($urandom);
            end
            if (!B_VLD || acc_b) begin
                B_VLD = 1'($urandom_range(0, 1));
                B     = SIZE'($urandom);
            end
            OUT_RDY = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
